alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle control sequencer that drives the processor's 16-bit ALU. The ALU computes ADD, SUB and NAND, and uses op 2'b11 as its idle code.
- Accepts 16-bit instruction words over a valid/ready handshake.
- Decodes them and reads operands from an internal 4x16 register file.
- Drives the ALU operand/op lines, then captures the ALU result and writes it back.
- Sits between the instruction source and the ALU.

Parameters:
DATA_W, 16, datapath width; must equal the ALU width.
NREGS, 4, register count; fixed at 4 (2-bit register fields).

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  instruction word present.
instr_ready  out  1  sequencer can accept an instruction.
instr  in  16  instruction word.
alu_a  out  DATA_W  operand A to ALU.
alu_b  out  DATA_W  operand B to ALU.
alu_op  out  2  ALU op: 00 ADD, 01 SUB, 10 NAND, 11 idle.
alu_result  in  DATA_W  combinational ALU result.
done  out  1  one-cycle pulse when an instruction retires.
illegal  out  1  one-cycle pulse when an illegal opcode is retired as a no-op.
zero_flag  out  1  set when the last written-back value was zero.
dbg_sel  in  2  register select for debug read.
dbg_data  out  DATA_W  combinational read of R[dbg_sel].

Behaviour:
Clock and reset: one clock; reset is asynchronous and active-low.

Reset values:
- State is IDLE; R0..R3 = 0; instruction register = 0.
- alu_a = 0, alu_b = 0, alu_op = 2'b11.
- done = 0, illegal = 0, zero_flag = 0.
- instr_ready is 1 once reset is released.

Instruction format:
- [15:13] opcode: 000 ADD, 001 SUB, 010 NAND, 011 LDI, 100 MOV, 101 NOP; 110 and 111 are illegal.
- [12:11] rd, [10:9] rs1, [8:7] rs2, [7:0] imm8 (LDI only, zero-extended).

Handshake:
- instr_ready = 1 only in IDLE.
- A transfer occurs on a clk edge with instr_valid & instr_ready; instr is latched into the instruction register.
- instr is ignored in all other states.
- instr_valid may be held high continuously; the next instruction is accepted on the first cycle back in IDLE.

FSM (registered state):
- IDLE: on transfer, go to DECODE.
- DECODE: latch alu_a = R[rs1] and alu_b = R[rs2], then go to EXEC. For ADD/SUB/NAND, alu_op takes the matching code; otherwise alu_op stays 11.
- EXEC: alu_op is held; capture alu_result into the result register, then go to WB.
  - LDI/MOV: the result register takes {8'h00, imm8} or R[rs1] respectively, and the ALU output is ignored.
  - NOP/illegal: no capture.
- WB:
  - Writes R[rd] for ADD/SUB/NAND/LDI/MOV.
  - Updates zero_flag = (result == 0) on every write.
  - Pulses done.
  - Pulses illegal for opcodes 110/111; these perform no write and leave zero_flag unchanged.
  - Sets alu_op = 11, then returns to IDLE.

Latency and throughput:
- An instruction accepted at edge N writes R[rd] at edge N+3.
- done is high during the cycle after edge N+3.
- Maximum throughput is 1 instruction per 4 cycles.

Boundary rules:
- Arithmetic wraps modulo 2^16: no carry or overflow output.
- rd may equal rs1/rs2. Operands are sampled in DECODE, so in-place update is correct.
- Writes to R0 are permitted; there is no hardwired zero.
- alu_op is 11 in IDLE and WB. alu_result is never sampled outside EXEC, so a high-Z result is harmless.
- dbg_data reflects a WB write from the cycle after the write edge.
- rst_n asserted mid-instruction aborts it immediately: all state returns to reset values and no done pulse is produced.

Decomposition:
Shared package (alu_pkg):
- ALU op codes: ADD = 2'b00, SUB = 2'b01, NAND = 2'b10, IDLE = 2'b11.
- Opcode constants: OPC_ADD through OPC_NOP.
- FSM state encoding.
- Instruction field bit positions.

One natural sub-module: regfile_4x16, with 2 combinational read ports, 1 debug read port, 1 synchronous write port, and async reset to 0.

Test Plan:
1. Reset, then LDI R1,5 and LDI R2,3, then SUB R3,R1,R2 -> dbg R3 = 0x0002; done pulses 3 cycles after each accept; instr_ready low for 3 cycles after each accept.
2. LDI R0,0xFF, then NAND R0,R0,R0 -> R0 = 0xFF00; ADD R1,R0,R0 -> R1 = 0xFE00 (wraps); zero_flag = 0.
3. SUB R2,R1,R1 -> R2 = 0x0000 and zero_flag = 1. Opcode 3'b111 -> illegal pulse and done pulse; registers and zero_flag unchanged.
4. Hold instr_valid high with 3 back-to-back words -> exactly 3 accepts, spaced 4 cycles apart; alu_op = 11 in every IDLE and WB cycle.
5. Drop rst_n during EXEC of ADD -> all outputs return to reset values asynchronously; no done pulse; the targeted register reads 0.
6. MOV R3,R1 after LDI R1,0x7A -> R3 = 0x007A, and alu_op stays 11 throughout the MOV.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, opcodes, instruction field layout and sequencer states
package alu_pkg;
  localparam int INSTR_W = 16;
  localparam int IMM_W = 8;
  localparam int OPC_LSB = 13;
  localparam int RD_LSB = 11;
  localparam int RS1_LSB = 9;
  localparam int RS2_LSB = 7;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_IDLE = 2'b11;
  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_NAND = 3'b010;
  localparam logic [2:0] OPC_LDI = 3'b011;
  localparam logic [2:0] OPC_MOV = 3'b100;
  localparam logic [2:0] OPC_NOP = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
  function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
    return opc == OPC_ADD ? ALU_ADD : opc == OPC_SUB ? ALU_SUB : opc == OPC_NAND ? ALU_NAND : ALU_IDLE;
  endfunction
endpackage

// File: rtl/regfile_4x16.sv
// regfile_4x16: register file with two operand reads, a debug read and one synchronous write
module regfile_4x16 #(
  parameter int DATA_W = 16,
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [1:0]        ra1,
  input  logic [1:0]        ra2,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] r_q [NREGS];
  logic [DATA_W-1:0] r_d [NREGS];
  always_comb begin
    r_d = r_q;
    if (we) r_d[wa] = wd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
    else r_q <= r_d;
  end
  assign rd1 = r_q[ra1];
  assign rd2 = r_q[ra2];
  assign dbg_data = r_q[dbg_sel];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state decode/execute/writeback controller wrapped around an external ALU
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [1:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               done,
  output logic               illegal,
  output logic               zero_flag,
  input  logic [1:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);
  state_t state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, rd1, rd2;
  logic [1:0] op_q, op_d;
  logic done_q, done_d, ill_q, ill_d, zf_q, zf_d, we;
  logic [2:0] opc;
  logic [1:0] rd, rs1, rs2;
  logic [IMM_W-1:0] imm;
  logic is_alu, is_wr, is_ill;
  assign opc = ir_q[OPC_LSB +: 3];
  assign rd = ir_q[RD_LSB +: 2];
  assign rs1 = ir_q[RS1_LSB +: 2];
  assign rs2 = ir_q[RS2_LSB +: 2];
  assign imm = ir_q[IMM_W-1:0];
  assign is_alu = alu_op_of(opc) != ALU_IDLE;
  assign is_wr = opc < OPC_NOP;
  assign is_ill = opc > OPC_NOP;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    zf_d = zf_q;
    done_d = 1'b0;
    ill_d = 1'b0;
    we = 1'b0;
    case (state_q)
      S_IDLE: begin
        ir_d = instr_valid ? instr : ir_q;
        state_d = instr_valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        a_d = rd1;
        b_d = rd2;
        op_d = alu_op_of(opc);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // a_q already holds R[rs1]; nothing writes the file before WB
        res_d = is_alu ? alu_result : opc == OPC_LDI ? {{(DATA_W-IMM_W){1'b0}}, imm} : opc == OPC_MOV ? a_q : res_q;
        op_d = ALU_IDLE;
        state_d = S_WB;
      end
      default: begin
        we = is_wr;
        zf_d = is_wr ? res_q == '0 : zf_q;
        done_d = 1'b1;
        ill_d = is_ill;
        op_d = ALU_IDLE;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= ALU_IDLE;
      res_q <= '0;
      zf_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      zf_q <= zf_d;
      done_q <= done_d;
      ill_q <= ill_d;
    end
  end
  regfile_4x16 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(rd), .wd(res_q),
    .ra1(rs1), .ra2(rs2), .dbg_sel(dbg_sel),
    .rd1(rd1), .rd2(rd2), .dbg_data(dbg_data)
  );
  assign instr_ready = state_q == S_IDLE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign done = done_q;
  assign illegal = ill_q;
  assign zero_flag = zf_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of the sequencer against a behavioural ALU
module tb_alu_sequencer;
  logic clk = 0, rst_n = 0, instr_valid = 0;
  logic [15:0] instr = 0, alu_a, alu_b, alu_result, dbg_data;
  logic [1:0] alu_op, dbg_sel = 0;
  logic instr_ready, done, illegal, zero_flag;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign alu_result = alu_op == 2'b00 ? alu_a + alu_b : alu_op == 2'b01 ? alu_a - alu_b :
                      alu_op == 2'b10 ? ~(alu_a & alu_b) : 16'hDEAD;
  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .illegal(illegal), .zero_flag(zero_flag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask
  function automatic logic [15:0] rr(input logic [2:0] opc, input logic [1:0] rd, rs1, rs2);
    return {opc, rd, rs1, rs2, 7'b0};
  endfunction
  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b011, rd, 3'b000, imm};
  endfunction
  task automatic reg_is(input string tag, input logic [1:0] r, input logic [15:0] exp);
    dbg_sel = r;
    #1 chk(tag, dbg_data, exp);
  endtask
  task automatic run(input string tag, input logic [15:0] w, input logic [1:0] exec_op, input logic ill);
    @(negedge clk);
    chk({tag, "_ready_pre"}, instr_ready, 1);
    instr = w;
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    instr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_ready_busy"}, instr_ready, 0);
      chk({tag, "_done_early"}, done, 0);
      chk({tag, "_op"}, alu_op, k == 1 ? exec_op : 2'b11);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_illegal"}, illegal, ill);
    chk({tag, "_ready_back"}, instr_ready, 1);
  endtask
  initial begin
    logic [15:0] words [3];
    int acc, last, wbc;
    repeat (2) @(negedge clk);
    chk("rst_op", alu_op, 2'b11);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_flags", {done, illegal, zero_flag}, 0);
    for (int r = 0; r < 4; r++) reg_is("rst_reg", 2'(r), 0);
    rst_n = 1;
    #1 chk("rst_ready", instr_ready, 1);
    run("ldi_r1", ldi(1, 8'h05), 2'b11, 0);
    run("ldi_r2", ldi(2, 8'h03), 2'b11, 0);
    run("sub_r3", rr(3'b001, 3, 1, 2), 2'b01, 0);
    reg_is("sub_r3_val", 3, 16'h0002);
    reg_is("ldi_r1_val", 1, 16'h0005);
    run("ldi_r0", ldi(0, 8'hFF), 2'b11, 0);
    run("nand_r0", rr(3'b010, 0, 0, 0), 2'b10, 0);
    reg_is("nand_r0_val", 0, 16'hFF00);
    run("add_r1", rr(3'b000, 1, 0, 0), 2'b00, 0);
    reg_is("add_wrap", 1, 16'hFE00);
    chk("zf_nonzero", zero_flag, 0);
    run("sub_zero", rr(3'b001, 2, 1, 1), 2'b01, 0);
    reg_is("sub_zero_val", 2, 16'h0000);
    chk("zf_set", zero_flag, 1);
    run("ill", rr(3'b111, 3, 1, 0), 2'b11, 1);
    chk("ill_zf_kept", zero_flag, 1);
    reg_is("ill_r0", 0, 16'hFF00);
    reg_is("ill_r1", 1, 16'hFE00);
    reg_is("ill_r3", 3, 16'h0002);
    @(negedge clk);
    chk("ill_pulse_end", {done, illegal}, 0);
    words[0] = ldi(0, 8'h11);
    words[1] = rr(3'b000, 1, 0, 0);
    words[2] = rr(3'b001, 2, 1, 0);
    acc = 0; last = 0; wbc = -1;
    instr_valid = 1;
    instr = words[0];
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (instr_ready || c == wbc) chk("b2b_idle_op", alu_op, 2'b11);
      if (instr_valid && instr_ready) begin
        if (acc > 0) chk("b2b_spacing", c - last, 4);
        last = c; wbc = c + 3; acc++;
        @(posedge clk);
        #1 if (acc < 3) instr = words[acc];
        else begin instr_valid = 0; instr = 0; end
      end
    end
    chk("b2b_accepts", acc, 3);
    reg_is("b2b_r1", 1, 16'h0022);
    reg_is("b2b_r2", 2, 16'h0011);
    @(negedge clk);
    instr = rr(3'b000, 2, 1, 1);
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    repeat (2) @(negedge clk);
    chk("abort_in_exec", {alu_op, alu_a}, {2'b00, 16'h0022});
    rst_n = 0;
    #1 chk("abort_op", alu_op, 2'b11);
    chk("abort_ab", {alu_a, alu_b}, 0);
    chk("abort_flags", {done, illegal, zero_flag}, 0);
    reg_is("abort_rd", 2, 0);
    reg_is("abort_r1", 1, 0);
    @(negedge clk);
    rst_n = 1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc += int'(done);
    end
    chk("abort_no_done", acc, 0);
    reg_is("abort_rd_after", 2, 0);
    run("ldi_7a", ldi(1, 8'h7A), 2'b11, 0);
    run("mov", rr(3'b100, 3, 1, 0), 2'b11, 0);
    reg_is("mov_val", 3, 16'h007A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
